// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
// spi_slave_if: pin-level SPI signals plus the byte-level core interface
// of spi_slave, bundled so the bench and the responder share one port list.
//
//   SPI pins  : cs_n, sclk, mosi (to responder); miso, miso_oe (from it)
//   tx side   : tx_data, tx_valid (to responder); tx_ready, tx_underrun
//   rx side   : rx_data, rx_valid (from responder)
//   status    : busy (from responder)
//
// modport slave  - the responder (spi_slave)
// modport master - whatever drives the pins and feeds/consumes bytes
interface spi_slave_if;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport slave (
    input  cs_n, sclk, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, busy
  );

  modport master (
    output cs_n, sclk, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI mode 0 (CPOL=0, CPHA=0) responder, MSB first, 8-bit frames.
//
// Ports
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_slave_if.slave
//     cs_n/sclk/mosi  asynchronous SPI inputs, synchronised here
//     miso/miso_oe    SPI output and its enable (enable == selected)
//     tx_data/tx_valid/tx_ready  one-deep transmit holding buffer
//     tx_underrun     pulse: a byte started with the holding buffer empty
//     rx_data/rx_valid  last received byte and its one-cycle strobe
//     busy            high while the FSM is ACTIVE (this is the FSM state)
//
// tx handshake: a byte is transferred on every clk edge where tx_valid and
// tx_ready are both high. tx_ready is high exactly when the holding buffer
// is empty; tx_valid may be raised at any time and tx_data must be stable
// while it is high. rx_valid has no back-pressure: rx_data is held until
// the next complete byte replaces it.
//
// SYNC_STAGES (2..3) sets the synchroniser depth; sclk high and low phases
// must each last at least SYNC_STAGES+2 clk periods.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  spi_slave_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_d;

  // Synchronisers and previous-value registers for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;

  // After reset the synchronisers hold idle levels, so a cs_n that stayed
  // low on the pin would look like a fresh falling edge. flush_sr marks when
  // the chains carry real pin values; armed then requires cs_n to be seen
  // high before any falling edge can open a frame.
  logic [SYNC_STAGES:0] flush_sr;
  logic                 armed;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // Datapath
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [6:0] rx_shift;
  logic [7:0] hold_data;
  logic       hold_full;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       underrun_r;
  logic       load;

  // FSM decode strobes
  logic consume;
  logic shift_tx;
  logic rx_edge;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev & armed;
  assign cs_rise   = cs_s & ~cs_prev;

  assign load = bus.tx_valid & ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      flush_sr  <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      flush_sr  <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      armed     <= armed | (flush_sr[SYNC_STAGES] & cs_s);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state and per-cycle datapath strobes
  always_comb begin
    state_d  = state;
    consume  = 1'b0;
    shift_tx = 1'b0;
    rx_edge  = 1'b0;
    case (state)
      IDLE: begin
        // sclk edges are ignored here
        if (cs_fall) begin
          state_d = ACTIVE;
          consume = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          rx_edge = sclk_rise;
          if (sclk_fall) begin
            // bit_cnt==0 on a falling edge means 8 bits just completed
            if (bit_cnt != 3'd0) begin
              shift_tx = 1'b1;
            end else begin
              consume = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      tx_shift   <= 8'hFF;
      rx_shift   <= 7'd0;
      hold_data  <= 8'h00;
      hold_full  <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;

      // A load coinciding with a consume of an empty buffer is not bypassed
      // into tx_shift: that byte waits for the next boundary.
      if (consume) begin
        if (hold_full) begin
          tx_shift <= hold_data;
        end else begin
          tx_shift   <= 8'hFF;
          underrun_r <= 1'b1;
        end
      end else if (shift_tx) begin
        tx_shift <= tx_shift << 1;
      end

      if (consume && hold_full) begin
        hold_full <= 1'b0;
      end else if (load) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
      end

      // Entering or leaving ACTIVE restarts the byte; a partial rx byte is
      // simply abandoned in rx_shift.
      if (state_d != state) begin
        bit_cnt <= 3'd0;
      end else if (rx_edge) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (rx_edge) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          rx_data_r  <= {rx_shift, mosi_s};
          rx_valid_r <= 1'b1;
        end
      end
    end
  end

  assign bus.miso        = (state == ACTIVE) ? tx_shift[7] : 1'b1;
  assign bus.miso_oe     = (state == ACTIVE);
  assign bus.busy        = (state == ACTIVE);
  assign bus.tx_ready    = ~hold_full;
  assign bus.tx_underrun = underrun_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// tb_spi_slave: directed bench for spi_slave. A pin-level master model
// drives cs_n/sclk/mosi with sclk half-period HALF clk cycles. Expected rx
// bytes and expected miso bytes are queued as stimulus is issued; two
// monitors pop and compare whenever the DUT presents a byte.
module tb_spi_slave;

  localparam int HALF     = 4;
  localparam int LB_BYTES = 256;

  logic clk;
  logic rst;

  spi_slave_if bus ();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  int         errors = 0;
  int         checks = 0;
  int         un_cnt = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_e;
  logic [7:0] mo_e;
  logic [7:0] mo_sh;
  int         mo_cnt;
  logic [7:0] lb_tx [LB_BYTES];
  logic [7:0] lb_rx [LB_BYTES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rx monitor: compares every rx_valid strobe, counts underrun pulses
  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (bus.tx_underrun) un_cnt++;
      if (bus.rx_valid) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %02h with nothing expected", bus.rx_data);
        end else begin
          rx_e = exp_rx_q.pop_front();
          chk("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_e});
        end
      end
    end
  end

  // miso monitor: assembles bytes at sclk rising edges while driven
  initial begin : miso_monitor
    mo_cnt = 0;
    forever begin
      @(posedge bus.sclk or posedge bus.cs_n);
      if (bus.cs_n || !bus.miso_oe) begin
        mo_cnt = 0;
      end else begin
        mo_sh = {mo_sh[6:0], bus.miso};
        mo_cnt++;
        if (mo_cnt == 8) begin
          mo_cnt = 0;
          if (exp_miso_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got %02h with nothing expected", mo_sh);
          end else begin
            mo_e = exp_miso_q.pop_front();
            chk("miso_byte", {24'd0, mo_sh}, {24'd0, mo_e});
          end
        end
      end
    end
  end

  // Watchdog
  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // Driver tasks (all entered on a falling clk edge)
  task automatic load_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!bus.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("load_wait_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    if (bus.tx_ready) begin
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Sends the top n bits of b, MSB first, one full sclk period per bit
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_miso"},        {31'd0, bus.miso},        32'd1);
    chk({tag, "_miso_oe"},     {31'd0, bus.miso_oe},     32'd0);
    chk({tag, "_tx_ready"},    {31'd0, bus.tx_ready},    32'd1);
    chk({tag, "_tx_underrun"}, {31'd0, bus.tx_underrun}, 32'd0);
    chk({tag, "_rx_data"},     {24'd0, bus.rx_data},     32'h00);
    chk({tag, "_rx_valid"},    {31'd0, bus.rx_valid},    32'd0);
    chk({tag, "_busy"},        {31'd0, bus.busy},        32'd0);
  endtask

  initial begin : main
    int un0;
    int rv0;
    bus.cs_n     = 1'b1;
    bus.sclk     = 1'b0;
    bus.mosi     = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    rst          = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("por");
    repeat (4) @(negedge clk);

    // Single byte: tx A5, rx 3C
    load_tx(8'hA5);
    exp_miso_q.push_back(8'hA5);
    un0 = un_cnt;
    cs_low();
    chk("t1_tx_ready_after_cs", {31'd0, bus.tx_ready}, 32'd1);
    chk("t1_no_underrun", un_cnt - un0, 32'd0);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    exp_rx_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    cs_high();
    chk("t1_rx_held", {24'd0, bus.rx_data}, 32'h3C);

    // Back-to-back: tx 01,02; rx F0,0F
    load_tx(8'h01);
    exp_miso_q.push_back(8'h01);
    un0 = un_cnt;
    cs_low();
    load_tx(8'h02);
    exp_miso_q.push_back(8'h02);
    exp_rx_q.push_back(8'hF0);
    exp_rx_q.push_back(8'h0F);
    send_bits(8'hF0, 8);
    send_bits(8'h0F, 8);
    cs_high();
    // only the trailing boundary after the last byte finds the buffer empty
    chk("t2_underrun", un_cnt - un0, 32'd1);

    // Underrun: empty at cs fall, 77 loaded mid-byte goes out next
    un0 = un_cnt;
    cs_low();
    chk("t3_underrun_at_start", un_cnt - un0, 32'd1);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h55);
    send_bits(8'h55, 4);
    load_tx(8'h77);
    exp_miso_q.push_back(8'h77);
    send_bits(8'h50, 4);
    chk("t3_rx_55", {24'd0, bus.rx_data}, 32'h55);
    chk("t3_underrun_after_byte1", un_cnt - un0, 32'd1);
    exp_rx_q.push_back(8'hC3);
    send_bits(8'hC3, 8);
    cs_high();
    chk("t3_underrun_total", un_cnt - un0, 32'd2);

    // Abort after 5 bits
    rv0 = rx_cnt;
    cs_low();
    send_bits(8'hAA, 5);
    repeat (2) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_busy_before_sync", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("t4_busy_low", {31'd0, bus.busy}, 32'd0);
    chk("t4_miso_oe_low", {31'd0, bus.miso_oe}, 32'd0);
    chk("t4_miso_high", {31'd0, bus.miso}, 32'd1);
    repeat (8) @(negedge clk);
    chk("t4_no_rx_valid", rx_cnt - rv0, 32'd0);
    chk("t4_rx_data_kept", {24'd0, bus.rx_data}, 32'hC3);
    load_tx(8'h5A);
    exp_miso_q.push_back(8'h5A);
    cs_low();
    exp_rx_q.push_back(8'h81);
    send_bits(8'h81, 8);
    cs_high();
    chk("t4_next_frame_rx", {24'd0, bus.rx_data}, 32'h81);

    // Reset mid-frame after 3 bits, with the holding buffer full
    load_tx(8'h96);
    cs_low();
    load_tx(8'h3B);
    chk("t5_buffer_full", {31'd0, bus.tx_ready}, 32'd0);
    send_bits(8'hE0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("t5_rst");
    rv0 = rx_cnt;
    send_bits(8'h00, 5);
    send_bits(8'hFF, 8);
    chk("t5_busy_stays_low", {31'd0, bus.busy}, 32'd0);
    chk("t5_no_rx_valid", rx_cnt - rv0, 32'd0);
    cs_high();
    load_tx(8'hE7);
    exp_miso_q.push_back(8'hE7);
    cs_low();
    exp_rx_q.push_back(8'h18);
    send_bits(8'h18, 8);
    cs_high();
    chk("t5_fresh_frame_rx", {24'd0, bus.rx_data}, 32'h18);

    // Loopback: 256 random bytes each way in one frame
    for (int i = 0; i < LB_BYTES; i++) begin
      lb_tx[i] = 8'($urandom_range(0, 255));
      lb_rx[i] = 8'($urandom_range(0, 255));
    end
    load_tx(lb_tx[0]);
    exp_miso_q.push_back(lb_tx[0]);
    un0 = un_cnt;
    cs_low();
    fork
      begin
        for (int i = 1; i < LB_BYTES; i++) begin
          load_tx(lb_tx[i]);
          exp_miso_q.push_back(lb_tx[i]);
        end
      end
      begin
        for (int j = 0; j < LB_BYTES; j++) begin
          exp_rx_q.push_back(lb_rx[j]);
          send_bits(lb_rx[j], 8);
        end
      end
    join
    cs_high();
    chk("lb_underrun_only_trailing", un_cnt - un0, 32'd1);

    repeat (20) @(negedge clk);
    chk("rx_queue_drained", exp_rx_q.size(), 32'd0);
    chk("miso_queue_drained", exp_miso_q.size(), 32'd0);
    chk("rx_total", rx_cnt, 32'd263);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
